// File: rtl/mul_iter_rv.sv
// Iterative RV32M multiplier: RADIX_BITS multiplier bits per cycle via shift-and-add
// over operand magnitudes, sign applied once at the end, valid/ready on both sides.
module mul_iter_rv #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
        return neg ? (~p + 1'b1) : p;
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [2*WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]        mag_a_q, mag_a_d;
    logic [WIDTH-1:0]        mag_b_q, mag_b_d;
    logic                    neg_q, neg_d;
    logic [1:0]              op_q, op_d;
    logic [WIDTH-1:0]        result_q, result_d;

    logic                    a_signed, b_signed;
    logic [RADIX_BITS-1:0]   group;
    logic [WIDTH+RADIX_BITS-1:0] partial, hi_sum;
    logic [2*WIDTH-1:0]      acc_step, full;

    // The accumulator shifts right each step, so the add is only WIDTH+RADIX_BITS wide.
    always_comb begin
        a_signed = (op == 2'b01) || (op == 2'b10);
        b_signed = (op == 2'b01);
        group    = mag_b_q[RADIX_BITS-1:0];
        partial  = {{RADIX_BITS{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, group};
        hi_sum   = {{RADIX_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + partial;
        acc_step = {hi_sum, acc_q[WIDTH-1:RADIX_BITS]};
        full     = apply_sign(acc_step, neg_q);
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !kill) begin
                    state_d = BUSY;
                    mag_a_d = magnitude(a, a_signed);
                    mag_b_d = magnitude(b, b_signed);
                    neg_d   = (a_signed & a[WIDTH-1]) ^ (b_signed & b[WIDTH-1]);
                    op_d    = op;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            BUSY: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_step;
                    mag_b_d = mag_b_q >> RADIX_BITS;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(N - 1)) begin
                        state_d  = DONE;
                        count_d  = '0;
                        result_d = (op_q == 2'b00) ? full[WIDTH-1:0] : full[2*WIDTH-1:WIDTH];
                    end
                end
            end
            DONE: begin
                if (kill || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Operand registers are only meaningful once an operation is accepted.
    always_ff @(posedge clk) begin
        mag_a_q <= mag_a_d;
        mag_b_q <= mag_b_d;
        neg_q   <= neg_d;
        op_q    <= op_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_mul_iter_rv.sv
// Bench for mul_iter_rv: directed literal cases plus a randomized run checked every
// cycle against a wide-arithmetic reference with a cycle-count timing model.
module tb_mul_iter_rv;

    localparam int W = 32;
    localparam int R = 2;
    localparam int N = W / R;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, kill, out_valid, out_ready;
    logic [1:0]   op;
    logic [W-1:0] a, b, result;

    logic         s_in_valid, s_in_ready, s_kill, s_out_valid, s_out_ready;
    logic [1:0]   s_op;
    logic [15:0]  s_a, s_b, s_result;

    mul_iter_rv #(.WIDTH(W), .RADIX_BITS(R)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    mul_iter_rv #(.WIDTH(16), .RADIX_BITS(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
        .a(s_a), .b(s_b), .kill(s_kill), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Full 64-bit product of sign/zero-extended operands, then pick the half.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe, ye, p;
        xe = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
        ye = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = xe * ye;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Timing model: 0 = waiting for work, 1 = computing (m_left edges to go), 2 = holding a result.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_exp   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid && !kill) begin
                    m_phase = 1;
                    m_left  = N;
                    m_exp   = ref_mul(op, a, b);
                end
                1: if (kill) m_phase = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) m_phase = 2;
                   end
                default: if (kill || out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", {63'b0, in_ready}, {63'b0, m_phase == 0});
            chk("model_out_valid", {63'b0, out_valid}, {63'b0, m_phase == 2});
            if (m_phase == 2) chk("model_result", {32'b0, result}, {32'b0, m_exp});
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("issue_timeout", 64'd0, 64'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [1:0]  t_op  [6] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    logic [31:0] t_a   [6] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b   [6] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
    logic [31:0] t_res [6] = '{32'd42, 32'h4000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        int lat;
        int ops;
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        s_in_valid = 1'b0; s_kill = 1'b0; s_out_ready = 1'b0; s_op = '0; s_a = '0; s_b = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_result", {32'b0, result}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Literal products, including sign corner cases.
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(lat);
            chk($sformatf("literal_lat_%0d", i), 64'(lat), 64'(N));
            chk($sformatf("literal_res_%0d", i), {32'b0, result}, {32'b0, t_res[i]});
            retire();
        end

        // Result held under backpressure, then immediate re-issue after handoff.
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_result", {32'b0, result}, 64'd0);
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", {63'b0, in_ready}, 64'd1);
        chk("bp_idle_out_valid", {63'b0, out_valid}, 64'd0);
        in_valid = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_reaccept", {63'b0, in_ready}, 64'd0);
        wait_done(lat);
        chk("bp_second_res", {32'b0, result}, 64'd6);
        retire();

        // Kill at count 8, then a back-to-back multiply.
        issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (8) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_in_ready", {63'b0, in_ready}, 64'd1);
        chk("kill_out_valid", {63'b0, out_valid}, 64'd0);
        issue(2'b00, 32'd3, 32'd5);
        wait_done(lat);
        chk("after_kill_lat", 64'(lat), 64'(N));
        chk("after_kill_res", {32'b0, result}, 64'd15);
        retire();

        // Reset in the middle of a computation.
        issue(2'b00, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_mid_result", {32'b0, result}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Narrow radix-4 instance: MULH 0x8000 x 0x0002 = -0x10000.
        s_in_valid = 1'b1; s_op = 2'b01; s_a = 16'h8000; s_b = 16'h0002;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (s_out_valid) break;
        end
        chk("w16_lat", 64'(lat), 64'd4);
        chk("w16_result", {48'b0, s_result}, 64'h0000_FFFF);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;

        // Randomized traffic with kill and out_ready noise; the compare process checks every cycle.
        ops = 0;
        for (int c = 0; c < 45000 && ops < 1500; c++) begin
            @(posedge clk); #1;
            if (in_valid && in_ready && !kill) ops++;
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = 2'($urandom_range(0, 3));
            a         = pick();
            b         = pick();
            kill      = ($urandom_range(0, 99) < 3);
            out_ready = ($urandom_range(0, 9) < 6);
        end
        in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
        chk("drain_idle", {63'b0, in_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
